// File: rtl/eth_tx_scheduler_if.sv
// Handshake bundle between the per-output-port TX scheduler and its input FIFOs / downstream client.
// master = scheduler side, slave = FIFO/client side.
interface eth_tx_scheduler_if;
  logic [3:0] FifoEmpty;
  logic [1:0] SelSt;
  logic       TxReady;
  logic       TxWait;
  logic [3:0] FifoRdEn;
  logic [1:0] SelInput;
  logic       TxValid;
  logic       TxActive;
  logic       PktDone;
  logic       Timeout;

  modport master (
    input  FifoEmpty, SelSt, TxReady, TxWait,
    output FifoRdEn, SelInput, TxValid, TxActive, PktDone, Timeout
  );

  modport slave (
    output FifoEmpty, SelSt, TxReady, TxWait,
    input  FifoRdEn, SelInput, TxValid, TxActive, PktDone, Timeout
  );
endinterface

// File: rtl/eth_tx_scheduler.sv
// Round-robin TX scheduler: grants one of four FWFT input FIFOs (never SELF_PORT) per packet.
// Optional per-packet byte watchdog enabled by defining ETH_TX_SCHED_WATCHDOG_EN.
module eth_tx_scheduler #(
  parameter int SELF_PORT   = 0,
  parameter int MAX_PKT_LEN = 2047
) (
  input logic               TxClk,
  input logic               reset,
  eth_tx_scheduler_if.master bus
);

  localparam logic [1:0] SELF_IDX = SELF_PORT[1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_sel;
  logic [1:0] r_last_grant;
  logic       r_pkt_done;

  logic [1:0] w_grant_idx;
  logic       w_grant_vld;
  logic [1:0] w_cand;
  logic       w_sel_empty;
  logic       w_rd;
  logic [3:0] w_rd_en;
  logic       w_tx_valid;
  logic       w_tx_active;
  logic       w_end_pkt;
  logic       w_grant;

`ifdef ETH_TX_SCHED_WATCHDOG_EN
  localparam logic [10:0] LIMIT_M1 = 11'(MAX_PKT_LEN - 1);
  logic [10:0] r_cnt;
  logic        r_timeout;
  logic        w_wd_hit;
`endif

  assign w_sel_empty = bus.FifoEmpty[r_sel];
  assign w_grant     = (r_state == IDLE) && (w_next == XFER);

  // Search starts after the last grant; the last grant itself is checked last so a
  // lone active input is not locked out after its own packet.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_last_grant;
    w_cand      = r_last_grant;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last_grant + 2'(k);
      if (!w_grant_vld && (w_cand != SELF_IDX) && !bus.FifoEmpty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_rd        = 1'b0;
    w_rd_en     = 4'b0000;
    w_tx_valid  = 1'b0;
    w_tx_active = 1'b0;
    w_end_pkt   = 1'b0;
`ifdef ETH_TX_SCHED_WATCHDOG_EN
    w_wd_hit    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!bus.TxWait && w_grant_vld) begin
          w_next = XFER;
        end
      end
      XFER: begin
        w_tx_active    = 1'b1;
        w_tx_valid     = ~w_sel_empty;
        w_rd           = bus.TxReady & ~w_sel_empty;
        w_rd_en[r_sel] = w_rd;
        if (w_rd && bus.SelSt[1]) begin
          w_end_pkt = 1'b1;
          w_next    = IDLE;
        end
`ifdef ETH_TX_SCHED_WATCHDOG_EN
        else if (w_rd && (r_cnt == LIMIT_M1)) begin
          w_wd_hit = 1'b1;
          w_next   = ABORT;
        end
`endif
      end
      ABORT: begin
        // Drain the rest of the oversized packet without presenting it to the client.
        w_tx_active    = 1'b1;
        w_rd           = ~w_sel_empty;
        w_rd_en[r_sel] = w_rd;
        if (w_sel_empty || bus.SelSt[1]) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge TxClk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sel        <= 2'd0;
      r_last_grant <= SELF_IDX;
      r_pkt_done   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pkt_done <= w_end_pkt;
      if (w_grant) begin
        r_sel        <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
    end
  end

`ifdef ETH_TX_SCHED_WATCHDOG_EN
  always_ff @(posedge TxClk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 11'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_hit;
      if (w_grant) begin
        r_cnt <= 11'd0;
      end else if ((r_state == XFER) && w_rd) begin
        r_cnt <= r_cnt + 11'd1;
      end
    end
  end

  assign bus.Timeout = r_timeout;
`else
  assign bus.Timeout = 1'b0;
`endif

  assign bus.FifoRdEn = w_rd_en;
  assign bus.SelInput = r_sel;
  assign bus.TxValid  = w_tx_valid;
  assign bus.TxActive = w_tx_active;
  assign bus.PktDone  = r_pkt_done;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler with a small FWFT FIFO model per input.
module tb_eth_tx_scheduler;

  logic TxClk = 1'b0;
  logic reset = 1'b1;
  eth_tx_scheduler_if bus();

  eth_tx_scheduler #(.SELF_PORT(0), .MAX_PKT_LEN(16)) dut (
    .TxClk (TxClk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 TxClk = ~TxClk;

  int           fill   [4];
  int           rd_ptr [4];
  logic [255:0] is_last  [4];
  logic [255:0] is_first [4];
  logic [3:0]   hold;
  logic         m_clr;
  logic [3:0]   w_fe;
  logic [1:0]   w_st;
  logic [7:0]   w_p;

  int n_checks = 0;
  int n_fail   = 0;

  int n_reads, pd_cnt, to_cnt, rd_nr, viol_oh, viol_empty, gn, idle_run, min_gap;
  int glog [8];
  logic prev_act, seen_act;

  always_comb begin
    w_fe = 4'b0000;
    for (int i = 0; i < 4; i++) w_fe[i] = hold[i] | (rd_ptr[i] >= fill[i]);
    w_p  = rd_ptr[bus.SelInput][7:0];
    w_st = 2'b00;
    if (rd_ptr[bus.SelInput] < fill[bus.SelInput])
      w_st = {is_last[bus.SelInput][w_p], is_first[bus.SelInput][w_p]};
  end

  assign bus.FifoEmpty = w_fe;
  assign bus.SelSt     = w_st;

  // FIFO pop model and monitors
  always @(posedge TxClk) begin
    if (m_clr) begin
      for (int i = 0; i < 4; i++) rd_ptr[i] <= 0;
      n_reads <= 0; pd_cnt <= 0; to_cnt <= 0; rd_nr <= 0;
      viol_oh <= 0; viol_empty <= 0; gn <= 0; idle_run <= 0; min_gap <= 999;
      prev_act <= 1'b0; seen_act <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.FifoRdEn[i]) rd_ptr[i] <= rd_ptr[i] + 1;
      if (|bus.FifoRdEn) n_reads <= n_reads + 1;
      if (|bus.FifoRdEn && !bus.TxReady) rd_nr <= rd_nr + 1;
      if (bus.PktDone) pd_cnt <= pd_cnt + 1;
      if (bus.Timeout) to_cnt <= to_cnt + 1;
      if (($countones(bus.FifoRdEn) > 1) || (|bus.FifoRdEn && !bus.FifoRdEn[bus.SelInput]))
        viol_oh <= viol_oh + 1;
      if (|(bus.FifoRdEn & w_fe)) viol_empty <= viol_empty + 1;
      prev_act <= bus.TxActive;
      if (bus.TxActive) begin
        if (!prev_act) begin
          if (gn < 8) glog[gn] <= int'(bus.SelInput);
          gn <= gn + 1;
          if (seen_act && idle_run < min_gap) min_gap <= idle_run;
        end
        seen_act <= 1'b1;
        idle_run <= 0;
      end else begin
        idle_run <= idle_run + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test();
    reset   = 1'b1;
    m_clr   = 1'b1;
    hold    = 4'b0000;
    bus.TxReady = 1'b0;
    bus.TxWait  = 1'b0;
    for (int i = 0; i < 4; i++) fill[i] = 0;
    @(posedge TxClk); #1;
    m_clr = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge TxClk); #1;
    reset = 1'b0;
  endtask

  task automatic load(input int i, input int n, input bit last);
    for (int k = 0; k < n; k++) begin
      is_first[i][fill[i] + k] = (k == 0);
      is_last[i][fill[i] + k]  = last && (k == n - 1);
    end
    fill[i] = fill[i] + n;
  endtask

  task automatic wait_pd(input int target, input int budget);
    for (int c = 0; c < budget && pd_cnt < target; c++) begin
      @(posedge TxClk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int bad;
    m_clr = 1'b1;
    hold  = 4'b0000;
    bus.TxReady = 1'b0;
    bus.TxWait  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill[i] = 0; is_last[i] = '0; is_first[i] = '0;
    end

    // Reset state with traffic pending, then three-way round robin
    start_test();
    load(1, 64, 1'b1); load(2, 64, 1'b1); load(3, 64, 1'b1);
    bus.TxReady = 1'b1;
    @(negedge TxClk);
    chk("rst_rden",   32'(bus.FifoRdEn), 32'h0);
    chk("rst_sel",    32'(bus.SelInput), 32'h0);
    chk("rst_valid",  32'(bus.TxValid),  32'h0);
    chk("rst_active", 32'(bus.TxActive), 32'h0);
    chk("rst_pkt",    32'(bus.PktDone),  32'h0);
    chk("rst_to",     32'(bus.Timeout),  32'h0);
    release_rst();
    @(negedge TxClk);
    chk("a_idle_active", 32'(bus.TxActive), 32'h0);
    chk("a_idle_rden",   32'(bus.FifoRdEn), 32'h0);
    @(negedge TxClk);
    chk("a_lat_valid", 32'(bus.TxValid),  32'h1);
    chk("a_lat_sel",   32'(bus.SelInput), 32'h1);
    chk("a_lat_rden",  32'(bus.FifoRdEn), 32'h2);
    wait_pd(3, 600);
    chk("a_pktdone",  32'(pd_cnt),  32'd3);
    chk("a_reads",    32'(n_reads), 32'd192);
    chk("a_grants",   32'(gn),      32'd3);
    chk("a_g0",       32'(glog[0]), 32'd1);
    chk("a_g1",       32'(glog[1]), 32'd2);
    chk("a_g2",       32'(glog[2]), 32'd3);
    chk("a_gap",      32'(min_gap), 32'd1);
    chk("a_onehot",   32'(viol_oh), 32'd0);
    chk("a_rd_empty", 32'(viol_empty), 32'd0);
    repeat (3) @(negedge TxClk);
    chk("a_sel_hold",   32'(bus.SelInput), 32'h3);
    chk("a_end_active", 32'(bus.TxActive), 32'h0);

    // TxReady toggling on input 2
    start_test();
    load(2, 8, 1'b1);
    release_rst();
    for (int c = 0; c < 80 && pd_cnt < 1; c++) begin
      @(posedge TxClk); #1;
      bus.TxReady = ~bus.TxReady;
    end
    bus.TxReady = 1'b1;
    chk("b_pktdone", 32'(pd_cnt),    32'd1);
    chk("b_reads",   32'(n_reads),   32'd8);
    chk("b_rd_nr",   32'(rd_nr),     32'd0);
    chk("b_grant",   32'(glog[0]),   32'd2);
    chk("b_ptr",     32'(rd_ptr[2]), 32'd8);
    chk("b_onehot",  32'(viol_oh),   32'd0);

    // TxWait hold-off
    start_test();
    bus.TxWait  = 1'b1;
    bus.TxReady = 1'b1;
    load(3, 4, 1'b1);
    release_rst();
    bad = 0;
    repeat (10) begin
      @(negedge TxClk);
      if (bus.TxActive !== 1'b0) bad++;
    end
    chk("c_wait_active", 32'(bad), 32'd0);
    @(posedge TxClk); #1;
    bus.TxWait = 1'b0;
    @(negedge TxClk);
    chk("c_valid_pre", 32'(bus.TxValid), 32'h0);
    @(negedge TxClk);
    chk("c_valid",     32'(bus.TxValid),  32'h1);
    chk("c_sel",       32'(bus.SelInput), 32'h3);
    @(posedge TxClk); #1;
    bus.TxWait = 1'b1;
    wait_pd(1, 40);
    chk("c_pktdone", 32'(pd_cnt),  32'd1);
    chk("c_reads",   32'(n_reads), 32'd4);
    load(1, 2, 1'b1);
    bad = 0;
    repeat (5) begin
      @(negedge TxClk);
      if (bus.TxActive !== 1'b0) bad++;
    end
    chk("c_wait_again", 32'(bad), 32'd0);

    // Mid-packet stall on input 1
    start_test();
    load(1, 20, 1'b1);
    bus.TxReady = 1'b1;
    release_rst();
    for (int c = 0; c < 60 && rd_ptr[1] < 10; c++) begin
      @(posedge TxClk); #1;
    end
    hold[1] = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge TxClk);
      if (bus.TxValid !== 1'b0 || bus.FifoRdEn !== 4'b0000 || bus.TxActive !== 1'b1) bad++;
    end
    chk("d_stall", 32'(bad),       32'd0);
    chk("d_ptr10", 32'(rd_ptr[1]), 32'd10);
    @(posedge TxClk); #1;
    hold[1] = 1'b0;
    wait_pd(1, 60);
    chk("d_pktdone", 32'(pd_cnt),  32'd1);
    chk("d_reads",   32'(n_reads), 32'd20);

    // Oversized packet without last marker
    start_test();
    load(1, 20, 1'b0);
    bus.TxReady = 1'b1;
    release_rst();
`ifdef ETH_TX_SCHED_WATCHDOG_EN
    for (int c = 0; c < 80 && bus.Timeout !== 1'b1; c++) @(negedge TxClk);
    chk("e_timeout",  32'(bus.Timeout),  32'h1);
    chk("e_ptr16",    32'(rd_ptr[1]),    32'd16);
    chk("e_ab_valid", 32'(bus.TxValid),  32'h0);
    chk("e_ab_act",   32'(bus.TxActive), 32'h1);
    chk("e_ab_rden",  32'(bus.FifoRdEn), 32'h2);
    @(posedge TxClk); #1;
    bus.TxReady = 1'b0;
    bad = 0;
    for (int c = 0; c < 20 && bus.TxActive === 1'b1; c++) begin
      @(negedge TxClk);
      if (bus.TxValid !== 1'b0) bad++;
    end
    chk("e_drain_valid", 32'(bad),          32'd0);
    chk("e_idle",        32'(bus.TxActive), 32'h0);
    chk("e_ptr20",       32'(rd_ptr[1]),    32'd20);
    chk("e_to_cnt",      32'(to_cnt),       32'd1);
    chk("e_no_pktdone",  32'(pd_cnt),       32'd0);
`else
    for (int c = 0; c < 60 && rd_ptr[1] < 20; c++) begin
      @(posedge TxClk); #1;
    end
    repeat (3) @(negedge TxClk);
    chk("e_still_xfer", 32'(bus.TxActive), 32'h1);
    chk("e_no_to",      32'(bus.Timeout),  32'h0);
    chk("e_no_pktdone", 32'(pd_cnt),       32'd0);
    chk("e_ptr20",      32'(rd_ptr[1]),    32'd20);
    load(1, 1, 1'b1);
    wait_pd(1, 20);
    chk("e_pktdone", 32'(pd_cnt),  32'd1);
    chk("e_reads",   32'(n_reads), 32'd21);
    chk("e_to_cnt",  32'(to_cnt),  32'd0);
`endif

    // Reset in the middle of a packet
    start_test();
    load(2, 10, 1'b1);
    load(3, 10, 1'b1);
    bus.TxReady = 1'b1;
    release_rst();
    for (int c = 0; c < 40 && rd_ptr[2] < 4; c++) begin
      @(posedge TxClk); #1;
    end
    reset = 1'b1;
    #1;
    chk("f_rden",   32'(bus.FifoRdEn), 32'h0);
    chk("f_valid",  32'(bus.TxValid),  32'h0);
    chk("f_active", 32'(bus.TxActive), 32'h0);
    chk("f_sel",    32'(bus.SelInput), 32'h0);
    chk("f_pkt",    32'(bus.PktDone),  32'h0);
    chk("f_to",     32'(bus.Timeout),  32'h0);
    @(posedge TxClk); #1;
    reset = 1'b0;
    @(negedge TxClk);
    @(negedge TxClk);
    chk("f_regrant_sel", 32'(bus.SelInput), 32'h2);
    chk("f_regrant_act", 32'(bus.TxActive), 32'h1);
    chk("f_no_pktdone",  32'(pd_cnt),       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_scheduler.md
ETH_TX_SCHEDULER -- requirements
Module: eth_tx_scheduler

Interface
REQ-001 Parameter SELF_PORT, default 0: input index (0-3) that SHALL never be granted (own port).
REQ-002 Parameter MAX_PKT_LEN, default 2047: watchdog byte limit per packet (used only per REQ-026).
REQ-003 TxClk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 FifoEmpty  input  4  empty flag of the per-input first-word-fall-through FIFO feeding this output port, bit i = input i.
REQ-006 SelSt  input  2  status [last, first] at the head of the FIFO currently selected by SelInput.
REQ-007 TxReady  input  1  downstream client accepts the byte presented this cycle.
REQ-008 TxWait  input  1  hold-off; while high, no new packet SHALL be started.
REQ-009 FifoRdEn  output  4  read enable, one-hot or zero, bit i = input i.
REQ-010 SelInput  output  2  index of the granted (or most recently granted) input; drives the external data/status mux.
REQ-011 TxValid  output  1  selected FIFO head byte is valid for the client.
REQ-012 TxActive  output  1  high while a packet is granted (XFER or ABORT).
REQ-013 PktDone  output  1  one-cycle pulse after the last byte of a packet is read.
REQ-014 Timeout  output  1  one-cycle pulse when the watchdog aborts a packet.

Function
REQ-015 States SHALL be IDLE, XFER, ABORT; LastGrant (2 bits) SHALL record the most recently granted input.
REQ-016 IDLE: if TxWait=0 and any eligible input (not SELF_PORT) has FifoEmpty=0, the block SHALL register the first such input searching LastGrant+1, +2, +3 (mod 4), load SelInput and LastGrant, and enter XFER next cycle.
REQ-017 IDLE: FifoRdEn, TxValid, TxActive SHALL be 0; TxWait=1 SHALL keep IDLE regardless of FIFO state.
REQ-018 XFER: TxValid SHALL equal ~FifoEmpty[SelInput]; FifoRdEn[SelInput] SHALL equal TxReady & ~FifoEmpty[SelInput] (combinational, same cycle); other FifoRdEn bits 0.
REQ-019 XFER: a read with SelSt=2'b10 or 2'b11 SHALL end the packet: PktDone=1 next cycle, state IDLE next cycle.
REQ-020 XFER with FifoEmpty[SelInput]=1 mid-packet SHALL stall (no read, TxValid=0) without leaving XFER; TxWait SHALL NOT affect a packet in progress.
REQ-021 Back-to-back packets SHALL be separated by at least one IDLE cycle; grant latency from FIFO non-empty in IDLE to TxValid SHALL be one cycle.
REQ-022 Round-robin: with all three eligible inputs continuously non-empty, grants SHALL rotate in strictly increasing index order (mod 4) skipping SELF_PORT.
REQ-023 ABORT: FifoRdEn[SelInput] SHALL equal ~FifoEmpty[SelInput] independent of TxReady; TxValid=0; exit to IDLE the cycle after a byte with SelSt[1]=1 is read or FifoEmpty[SelInput]=1.
REQ-024 SelInput SHALL hold its value in IDLE until the next grant.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, FifoRdEn=0, SelInput=0, TxValid=0, TxActive=0, PktDone=0, Timeout=0, LastGrant=SELF_PORT, byte counter=0, including mid-packet; no PktDone on reset.

Configuration
REQ-026 Macro ETH_TX_SCHED_WATCHDOG_EN defined: an 11-bit byte counter SHALL clear on grant and increment per XFER read; a read reaching MAX_PKT_LEN without a last marker SHALL pulse Timeout next cycle and enter ABORT.
REQ-027 Macro ETH_TX_SCHED_WATCHDOG_EN undefined: no counter, Timeout tied 0, ABORT unreachable, packets of any length SHALL complete in XFER.

Verification
REQ-028 SELF_PORT=0; inputs 1,2,3 each hold one 64-byte packet, TxReady=1 -> grants 1,2,3 in order, 3 PktDone pulses, 192 reads, one IDLE cycle between packets.
REQ-029 Input 2 holds packet, TxReady toggling 1/0 -> FifoRdEn[2] only in TxReady=1 cycles, byte order preserved, PktDone once.
REQ-030 TxWait=1 with input 3 non-empty for 10 cycles -> TxActive stays 0; TxWait=0 -> TxValid high one cycle later.
REQ-031 Input 1 empties after byte 10 for 5 cycles, then resumes -> TxValid=0, no reads, state XFER for 5 cycles, packet completes.
REQ-032 Watchdog enabled, MAX_PKT_LEN=16, input 1 sends 20 bytes without last -> Timeout pulse after read 16, remaining bytes drained with TxValid=0, return to IDLE.
REQ-033 Assert reset during byte 5 of a packet -> all outputs 0 immediately, next grant searches from SELF_PORT+1.
